sd_rx_dma_writer: RTL
=====================

// Module: sd_rx_dma_writer
// PURPOSE
//  Parametrised RX DMA write master. Drains the read side of the SD RX FIFO to system memory over Wishbone.
//  Writes a programmed number of words from a base address.
//  Reports done/error to the SD data master control logic.
//  Single clock domain: the FIFO read port and the Wishbone bus both run on clk.
// PARAMETERS
//  DW        32  data width of FIFO word and Wishbone data bus (multiple of 8)
//  AW        32  Wishbone address width
//  LEN_W     9   width of word-count input len (max transfer 2^LEN_W-1 words)
//  BURST_LEN 4   beats per Wishbone burst (power of 2, >=2); used only with SD_RX_BURST_EN
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       synchronous reset, active-low
//  en           in   1       transfer enable; rising level in IDLE starts, low aborts/clears
//  adr          in   AW      byte base address, sampled at start
//  len          in   LEN_W   number of DW words to write, sampled at start
//  busy         out  1       transfer in progress (LOAD/WRITE)
//  done         out  1       all len words acked; held until en low
//  err          out  1       m_wb_err_i seen; sticky until en low
//  fifo_dat     in   DW      FIFO head word (first-word-fall-through, valid when !fifo_empty)
//  fifo_empty   in   1       FIFO empty
//  fifo_rd      out  1       pop strobe, one cycle per word consumed
//  m_wb_adr_o   out  AW      byte address = base + words_done*(DW/8)
//  m_wb_dat_o   out  DW      write data (registered)
//  m_wb_sel_o   out  DW/8    all ones while stb, else 0
//  m_wb_we_o    out  1       1 whenever cyc
//  m_wb_cyc_o   out  1       bus cycle
//  m_wb_stb_o   out  1       strobe
//  m_wb_cti_o   out  3       cycle type
//  m_wb_bte_o   out  2       burst type, constant 2'b00 (linear)
//  m_wb_ack_i   in   1       slave acknowledge
//  m_wb_err_i   in   1       slave error
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE.
//   All outputs 0, including adr offset, m_wb_dat_o, done, err and fifo_rd.
//  States: IDLE, LOAD, WRITE, DONE, ERR.
//  IDLE: en=1 -> latch adr, rem=len.
//   rem==0 -> DONE next cycle. Otherwise -> LOAD.
//  LOAD: wait for !fifo_empty.
//   Then fifo_rd=1 for one cycle and m_wb_dat_o<=fifo_dat.
//   cyc=stb=we=1 from the next cycle -> WRITE.
//  WRITE, on ack: offset += DW/8, rem -= 1.
//   rem reaches 0 -> cyc=stb=0 next cycle, -> DONE.
//  ack and err are both high: err takes priority. No offset increment -> ERR with cyc=stb=0.
//  DONE: done=1, busy=0; stays until en=0. ERR: err=1, busy=0; stays until en=0.
//  en=0 in any state: next cycle state=IDLE and cyc=stb=fifo_rd=0.
//   offset, done and err are cleared. A word already popped but not acked is discarded.
//  Only one fifo_rd per word. fifo_rd is never asserted when fifo_empty=1.
//  Offset arithmetic is AW-bit and wraps modulo 2^AW. No error is raised on wrap.
//  fifo_empty is ignored in IDLE, DONE and ERR.
// CONFIGURATION
//  SD_RX_BURST_EN undefined (classic mode):
//   - Each word is its own cycle with m_wb_cti_o=3'b000.
//   - cyc drops for 1 cycle after each ack; the FSM returns to LOAD.
//  SD_RX_BURST_EN defined (incrementing burst mode):
//   - cyc stays high across up to BURST_LEN beats; m_wb_cti_o=3'b010.
//   - cti=3'b111 on the last beat of the burst or of the transfer (rem==1).
//   - The next word is popped in the ack cycle when !fifo_empty, so back-to-back beats take 1 clk each.
//   - FIFO empty mid-burst: stb=0, cyc=1, cti held, until data arrives.
//   - cyc drops for 1 cycle between bursts.
// TESTING
//  1. adr=0x1000, len=3, FIFO preloaded A,B,C, ack 1 cycle after stb -> writes to 0x1000/4/8 with A/B/C. done=1, 3 fifo_rd pulses.
//  2. len=0, en=1 -> done=1 within 2 cycles; no cyc, no fifo_rd.
//  3. len=4, FIFO empty for 10 cycles after start, then 4 words -> no stb while empty; 4 correct writes; done.
//  4. err_i together with ack on word 2 of len=5 -> err=1, cyc=0 next cycle, done=0, offset stays 4. en=0 -> err clears.
//  5. en=0 mid-WRITE (stb high, no ack) -> cyc/stb=0 next cycle, state IDLE. Restart with adr=0x2000 -> first write at 0x2000.
//  6. SD_RX_BURST_EN, BURST_LEN=4, len=6, FIFO full -> bursts of 4+2 beats with cti 010,010,010,111 | 010,111. 1 idle cyc between bursts.

Source files
------------

// File: rtl/sd_rx_dma_writer.sv
// sd_rx_dma_writer -- RX DMA write master.
// Drains the first-word-fall-through SD RX FIFO into system memory as Wishbone
// write cycles. The transfer covers len words starting at byte address adr.
// Build option: define SD_RX_BURST_EN for incrementing bursts of BURST_LEN beats.
// Without it, each word is a single classic cycle.
module sd_rx_dma_writer #(
   parameter int DW        = 32,
   parameter int AW        = 32,
   parameter int LEN_W     = 9,
   parameter int BURST_LEN = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [AW-1:0]    adr,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             err,
   input  logic [DW-1:0]    fifo_dat,
   input  logic             fifo_empty,
   output logic             fifo_rd,
   output logic [AW-1:0]    m_wb_adr_o,
   output logic [DW-1:0]    m_wb_dat_o,
   output logic [DW/8-1:0]  m_wb_sel_o,
   output logic             m_wb_we_o,
   output logic             m_wb_cyc_o,
   output logic             m_wb_stb_o,
   output logic [2:0]       m_wb_cti_o,
   output logic [1:0]       m_wb_bte_o,
   input  logic             m_wb_ack_i,
   input  logic             m_wb_err_i
);

   localparam logic [AW-1:0] STEP = AW'(DW / 8);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE, S_ERR} state_e;

   state_e             state_q, state_d;
   logic [AW-1:0]      base_q, base_d;
   logic [AW-1:0]      off_q, off_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic [DW-1:0]      dat_q, dat_d;
   logic               cyc_q, cyc_d;
   logic               stb_q, stb_d;
   logic               pop;
   logic               beat_ack, beat_err;

   // A slave response only counts while a strobe is outstanding; err wins over ack.
   assign beat_err = stb_q && m_wb_err_i;
   assign beat_ack = stb_q && m_wb_ack_i && !m_wb_err_i;

`ifdef SD_RX_BURST_EN
   localparam int BEAT_W = $clog2(BURST_LEN);
   logic [BEAT_W-1:0]  beat_q, beat_d;
   logic               burst_last;

   // Last beat of a burst, or the final word of the whole transfer.
   assign burst_last = (beat_q == BEAT_W'(BURST_LEN - 1)) || (rem_q == LEN_W'(1));
`endif

   // Next-state, datapath updates and the FIFO pop strobe.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d = state_q;
      base_d  = base_q;
      off_d   = off_q;
      rem_d   = rem_q;
      dat_d   = dat_q;
      cyc_d   = cyc_q;
      stb_d   = stb_q;
      pop     = 1'b0;
`ifdef SD_RX_BURST_EN
      beat_d  = beat_q;
`endif
      if (!en) begin
         // Abort or clear: any popped-but-unacked word is simply dropped.
         state_d = S_IDLE;
         cyc_d   = 1'b0;
         stb_d   = 1'b0;
         off_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               base_d  = adr;
               rem_d   = len;
               off_d   = '0;
               state_d = (len == '0) ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  dat_d   = fifo_dat;
                  cyc_d   = 1'b1;
                  stb_d   = 1'b1;
                  state_d = S_WRITE;
`ifdef SD_RX_BURST_EN
                  beat_d  = '0;
`endif
               end
            end
            S_WRITE: begin
               if (beat_err) begin
                  cyc_d   = 1'b0;
                  stb_d   = 1'b0;
                  state_d = S_ERR;
               end else if (beat_ack) begin
                  off_d = off_q + STEP;
                  rem_d = rem_q - LEN_W'(1);
                  if (rem_q == LEN_W'(1)) begin
                     cyc_d   = 1'b0;
                     stb_d   = 1'b0;
                     state_d = S_DONE;
`ifdef SD_RX_BURST_EN
                  end else if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                     cyc_d   = 1'b0;
                     stb_d   = 1'b0;
                     state_d = S_LOAD;
                  end else begin
                     // Stay in the burst; fetch the next word in the ack cycle if present.
                     beat_d = beat_q + BEAT_W'(1);
                     pop    = !fifo_empty;
                     stb_d  = !fifo_empty;
                     if (!fifo_empty) dat_d = fifo_dat;
                  end
               end else if (!stb_q && !fifo_empty) begin
                  // Burst stalled on an empty FIFO: resume as soon as a word arrives.
                  pop   = 1'b1;
                  dat_d = fifo_dat;
                  stb_d = 1'b1;
`else
                  end else begin
                     cyc_d   = 1'b0;
                     stb_d   = 1'b0;
                     state_d = S_LOAD;
                  end
`endif
               end
            end
            S_DONE, S_ERR: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         off_q   <= '0;
         rem_q   <= '0;
         // NOTE: the write-data register is reset because it drives a bus port directly.
         dat_q   <= '0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
`ifdef SD_RX_BURST_EN
         beat_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         off_q   <= off_d;
         rem_q   <= rem_d;
         dat_q   <= dat_d;
         cyc_q   <= cyc_d;
         stb_q   <= stb_d;
`ifdef SD_RX_BURST_EN
         beat_q  <= beat_d;
`endif
      end
   end

   assign busy       = (state_q == S_LOAD) || (state_q == S_WRITE);
   assign done       = (state_q == S_DONE);
   assign err        = (state_q == S_ERR);
   assign fifo_rd    = pop;
   assign m_wb_adr_o = base_q + off_q;
   assign m_wb_dat_o = dat_q;
   assign m_wb_sel_o = {(DW / 8){stb_q}};
   assign m_wb_we_o  = cyc_q;
   assign m_wb_cyc_o = cyc_q;
   assign m_wb_stb_o = stb_q;
   assign m_wb_bte_o = 2'b00;
`ifdef SD_RX_BURST_EN
   assign m_wb_cti_o = cyc_q ? (burst_last ? 3'b111 : 3'b010) : 3'b000;
`else
   assign m_wb_cti_o = 3'b000;
`endif

endmodule
